// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a start bit, then
// shifts one byte plus odd parity and stop out on device clock falls and checks the ACK.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12_000,
    parameter int START_TIMEOUT  = 1_500_000,
    parameter int XFER_TIMEOUT   = 200_000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int TMAX_SX = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int TMAX    = (TMAX_SX > INHIBIT_CYCLES) ? TMAX_SX : INHIBIT_CYCLES;
    localparam int TW      = $clog2(TMAX + 1);
    localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TIMEOUT - 1);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_WAIT_FIRST, S_SHIFT, S_ACK, S_RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic            clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic            dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic            filt_clk_q, filt_clk_d;
    logic [FW-1:0]   filt_cnt_q, filt_cnt_d;
    logic            fall_q, fall_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [9:0]      shift_q, shift_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic            clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic            done_q, done_d, err_q, err_d;
    logic [1:0]      err_code_q, err_code_d;
    logic            tx_ready_q, tx_ready_d, busy_q, busy_d;
    logic            fail;
    logic [1:0]      fail_code;

    always_comb begin
        clk_s1_d   = ps2_clk_i;
        clk_s2_d   = clk_s1_q;
        dat_s1_d   = ps2_data_i;
        dat_s2_d   = dat_s1_q;
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_clk_q) begin
            if (filt_cnt_q == FLT_LAST) filt_clk_d = clk_s2_q;
            else                        filt_cnt_d = filt_cnt_q + FW'(1);
        end
        fall_d = filt_clk_q & ~filt_clk_d;

        state_d    = state_q;
        timer_d    = timer_q + TW'(1);
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        data_oe_d  = data_oe_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        fail       = 1'b0;
        fail_code  = 2'b00;

        // Timeouts are tested before fall so a coincident edge cannot rescue a frame
        case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                timer_d   = '0;
                if (tx_valid && tx_ready_q) begin
                    shift_d = {1'b1, ~^tx_data, tx_data};
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (timer_q == INH_LAST) begin
                    state_d   = S_REQ;
                    data_oe_d = 1'b1;
                    timer_d   = '0;
                end
            end
            S_REQ: state_d = S_WAIT_FIRST;
            S_WAIT_FIRST: begin
                if (timer_q == START_LAST) begin
                    fail      = 1'b1;
                    fail_code = 2'b01;
                end else if (fall_q) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b1, shift_q[9:1]};
                    bit_cnt_d = 4'd1;
                    timer_d   = TW'(1);
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (timer_q == XFER_LAST) begin
                    fail      = 1'b1;
                    fail_code = 2'b10;
                end else if (fall_q) begin
                    if (bit_cnt_q == 4'd10) begin
                        state_d   = S_ACK;
                        data_oe_d = 1'b0;
                    end else begin
                        data_oe_d = ~shift_q[0];
                        shift_d   = {1'b1, shift_q[9:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_ACK: begin
                if (timer_q == XFER_LAST) begin
                    fail      = 1'b1;
                    fail_code = 2'b10;
                end else if (!dat_s2_q) begin
                    state_d = S_RELEASE;
                end else begin
                    fail      = 1'b1;
                    fail_code = 2'b11;
                end
            end
            S_RELEASE: begin
                if (timer_q == XFER_LAST) begin
                    fail      = 1'b1;
                    fail_code = 2'b10;
                end else if (filt_clk_q && dat_s2_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            state_d    = S_IDLE;
            data_oe_d  = 1'b0;
            err_d      = 1'b1;
            err_code_d = fail_code;
        end

        clk_oe_d   = (state_d == S_INHIBIT) || (state_d == S_REQ);
        tx_ready_d = (state_d == S_IDLE) && !done_d && !err_d;
        busy_d     = !tx_ready_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
            timer_q    <= '0;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            filt_clk_q <= filt_clk_d;
            filt_cnt_q <= filt_cnt_d;
            fall_q     <= fall_d;
            timer_q    <= timer_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_ready    = tx_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model clocks frames out of the host
// and each captured frame is compared with one built from the odd-parity framing rules.
module tb_ps2_host_tx;

    localparam int INH  = 40;
    localparam int STO  = 1500;
    localparam int XTO  = 2000;
    localparam int FL   = 4;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, done, err;
    logic [1:0] err_code;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = !(ps2_clk_oe || dev_clk_low);
    assign ps2_data_line = !(ps2_data_oe || dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH), .START_TIMEOUT(STO), .XFER_TIMEOUT(XTO), .FILTER_LEN(FL)
    ) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done), .err(err), .err_code(err_code),
        .ps2_clk_i(ps2_clk_line), .ps2_data_i(ps2_data_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int done_cnt = 0, err_cnt = 0, err_cyc = 0, req_cyc = 0;
    int long_pulse = 0, ready_late = 0, clk_rises = 0, overlap = 0;
    int run = 0, last_run = 0;
    logic prev_done = 1'b0, prev_err = 1'b0, prev_clk_oe = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive observer of pulses and output-enable windows, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            prev_done   <= 1'b0;
            prev_err    <= 1'b0;
            prev_clk_oe <= 1'b0;
            run         <= 0;
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if (err) begin
                err_cnt <= err_cnt + 1;
                err_cyc <= cyc;
            end
            if ((done && prev_done) || (err && prev_err)) long_pulse <= long_pulse + 1;
            if ((prev_done || prev_err) && !tx_ready) ready_late <= ready_late + 1;
            if (ps2_clk_oe && !prev_clk_oe) clk_rises <= clk_rises + 1;
            if (ps2_clk_oe) run <= run + 1;
            else if (run > 0) begin
                last_run <= run;
                run      <= 0;
            end
            if (ps2_clk_oe && ps2_data_oe) begin
                overlap <= overlap + 1;
                req_cyc <= cyc;
            end
            prev_done   <= done;
            prev_err    <= err;
            prev_clk_oe <= ps2_clk_oe;
        end
    end

    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        int ones;
        logic [10:0] f;
        ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [1:0] acc_obs);
        int t;
        tx_data  = b;
        tx_valid = 1'b1;
        t = 0;
        while (!tx_ready && t < 3000) begin
            tick(1);
            t++;
        end
        tick(1);
        tx_valid = 1'b0;
        acc_obs  = {busy, ps2_clk_oe};
    endtask

    task automatic device_frame(input int n_edges, input bit give_ack,
                                output logic [10:0] got, output bit started, output int first_fall);
        int t;
        got = '0;
        started = 1'b0;
        first_fall = 0;
        t = 0;
        while (!(ps2_clk_line === 1'b1 && ps2_data_line === 1'b0) && t < INH + 200) begin
            tick(1);
            t++;
        end
        if (t >= INH + 200) return;
        started = 1'b1;
        tick(HALF);
        got[0] = ps2_data_line;
        for (int e = 1; e <= n_edges; e++) begin
            if (e == 11 && give_ack) begin
                dev_data_low = 1'b1;
                tick(10);
            end
            dev_clk_low = 1'b1;
            if (e == 1) first_fall = cyc;
            tick(HALF);
            dev_clk_low = 1'b0;
            if (e <= 10) got[e] = ps2_data_line;
            tick(HALF);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_end(input int base, input int budget);
        int t;
        t = 0;
        while ((done_cnt + err_cnt) == base && t < budget) begin
            tick(1);
            t++;
        end
        tick(2);
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        rst = 1'b1;
        tick(4);
        obs = {tx_ready, busy, done, err, err_code, ps2_clk_oe, ps2_data_oe};
        vectors++;
        if (obs !== 8'b1000_0000) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %b expected 10000000", obs);
        end
        rst = 1'b0;
        tick(20);
        obs = {tx_ready, busy, done, err, err_code, ps2_clk_oe, ps2_data_oe};
        vectors++;
        if (obs !== 8'b1000_0000) begin
            miscompares++;
            $display("[TB] FAIL idle_outputs: got %b expected 10000000", obs);
        end
    endtask

    task automatic test_good_frames();
        logic [7:0]  bytes [4];
        logic [10:0] got;
        logic [1:0]  acc;
        bit          started;
        int          ff, b_done, b_err, b_ovl;
        bytes[0] = 8'hED;
        for (int i = 1; i < 4; i++) bytes[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) begin
            b_done = done_cnt;
            b_err  = err_cnt;
            b_ovl  = overlap;
            send_byte(bytes[i], acc);
            vectors++;
            if (acc !== 2'b11) begin
                miscompares++;
                $display("[TB] FAIL accept_busy_clkoe: got %b expected 11", acc);
            end
            device_frame(11, 1'b1, got, started, ff);
            wait_end(b_done + b_err, 300);
            vectors++;
            if (got !== ref_frame(bytes[i]) || !started) begin
                miscompares++;
                $display("[TB] FAIL frame_bits byte=%02h: got %b expected %b", bytes[i], got, ref_frame(bytes[i]));
            end
            vectors++;
            if ((done_cnt - b_done) !== 1 || (err_cnt - b_err) !== 0) begin
                miscompares++;
                $display("[TB] FAIL done_err_count: got done %0d err %0d expected 1 0", done_cnt - b_done, err_cnt - b_err);
            end
            vectors++;
            if (last_run !== INH + 1 || (overlap - b_ovl) !== 1) begin
                miscompares++;
                $display("[TB] FAIL clkoe_window: got run %0d overlap %0d expected %0d 1", last_run, overlap - b_ovl, INH + 1);
            end
        end
        vectors++;
        if (long_pulse !== 0 || ready_late !== 0) begin
            miscompares++;
            $display("[TB] FAIL pulse_shape: got long %0d late %0d expected 0 0", long_pulse, ready_late);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] got1, got2;
        logic [1:0]  acc;
        bit          s1, s2;
        int          ff, b_done, b_err, done_at_accept;
        b_done = done_cnt;
        b_err  = err_cnt;
        send_byte(8'h01, acc);
        device_frame(11, 1'b1, got1, s1, ff);
        send_byte(8'hFF, acc);
        done_at_accept = done_cnt - b_done;
        device_frame(11, 1'b1, got2, s2, ff);
        wait_end(b_done + b_err + 1, 300);
        vectors++;
        if (done_at_accept !== 1 || acc !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_accept: got done %0d acc %b expected 1 11", done_at_accept, acc);
        end
        vectors++;
        if (got1 !== ref_frame(8'h01) || got1[9] !== 1'b0 || !s1) begin
            miscompares++;
            $display("[TB] FAIL b2b_frame_01: got %b expected %b", got1, ref_frame(8'h01));
        end
        vectors++;
        if (got2 !== ref_frame(8'hFF) || got2[9] !== 1'b1 || !s2) begin
            miscompares++;
            $display("[TB] FAIL b2b_frame_ff: got %b expected %b", got2, ref_frame(8'hFF));
        end
        vectors++;
        if ((done_cnt - b_done) !== 2 || (err_cnt - b_err) !== 0 || ready_late !== 0) begin
            miscompares++;
            $display("[TB] FAIL b2b_counts: got done %0d err %0d late %0d expected 2 0 0", done_cnt - b_done, err_cnt - b_err, ready_late);
        end
    endtask

    task automatic test_no_clock();
        logic [1:0] acc;
        int b_done, b_err;
        b_done = done_cnt;
        b_err  = err_cnt;
        send_byte(8'($urandom_range(0, 255)), acc);
        wait_end(b_done + b_err, STO + INH + 200);
        vectors++;
        if ((err_cnt - b_err) !== 1 || err_code !== 2'b01 || (done_cnt - b_done) !== 0) begin
            miscompares++;
            $display("[TB] FAIL no_clock_err: got err %0d code %b done %0d expected 1 01 0", err_cnt - b_err, err_code, done_cnt - b_done);
        end
        vectors++;
        if ((err_cyc - req_cyc) !== STO) begin
            miscompares++;
            $display("[TB] FAIL no_clock_latency: got %0d expected %0d", err_cyc - req_cyc, STO);
        end
        vectors++;
        if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL no_clock_release: got %b expected 001", {ps2_clk_oe, ps2_data_oe, tx_ready});
        end
    endtask

    task automatic test_no_ack();
        logic [7:0]  b;
        logic [10:0] got;
        logic [1:0]  acc;
        bit          started;
        int          ff, b_done, b_err;
        b = 8'($urandom_range(0, 255));
        b_done = done_cnt;
        b_err  = err_cnt;
        send_byte(b, acc);
        device_frame(11, 1'b0, got, started, ff);
        wait_end(b_done + b_err, 300);
        vectors++;
        if ((err_cnt - b_err) !== 1 || err_code !== 2'b11 || (done_cnt - b_done) !== 0) begin
            miscompares++;
            $display("[TB] FAIL no_ack_err: got err %0d code %b done %0d expected 1 11 0", err_cnt - b_err, err_code, done_cnt - b_done);
        end
        vectors++;
        if (got !== ref_frame(b) || !started) begin
            miscompares++;
            $display("[TB] FAIL no_ack_bits: got %b expected %b", got, ref_frame(b));
        end
    endtask

    task automatic test_stall();
        logic [7:0]  b;
        logic [10:0] got, exp;
        logic [1:0]  acc;
        bit          started;
        int          ff, b_done, b_err;
        vectors++;
        if (err_code !== 2'b11) begin
            miscompares++;
            $display("[TB] FAIL err_code_hold: got %b expected 11", err_code);
        end
        b = 8'($urandom_range(0, 255));
        exp = ref_frame(b);
        b_done = done_cnt;
        b_err  = err_cnt;
        send_byte(b, acc);
        device_frame(5, 1'b1, got, started, ff);
        wait_end(b_done + b_err, XTO + 200);
        vectors++;
        if ((err_cnt - b_err) !== 1 || err_code !== 2'b10 || (done_cnt - b_done) !== 0) begin
            miscompares++;
            $display("[TB] FAIL stall_err: got err %0d code %b done %0d expected 1 10 0", err_cnt - b_err, err_code, done_cnt - b_done);
        end
        vectors++;
        if ((err_cyc - ff) !== XTO + 2 + FL) begin
            miscompares++;
            $display("[TB] FAIL stall_latency: got %0d expected %0d", err_cyc - ff, XTO + 2 + FL);
        end
        vectors++;
        if (got[5:0] !== exp[5:0] || {ps2_clk_oe, ps2_data_oe} !== 2'b00 || !started) begin
            miscompares++;
            $display("[TB] FAIL stall_bits_release: got %b oe %b expected %b 00", got[5:0], {ps2_clk_oe, ps2_data_oe}, exp[5:0]);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0]  a, bb, c;
        logic [10:0] got;
        logic [1:0]  acc;
        bit          started;
        int          ff, b_done, b_err, b_rise;
        a  = 8'($urandom_range(0, 255));
        bb = ~a;
        c  = a ^ 8'h5A;
        b_done = done_cnt;
        b_err  = err_cnt;
        send_byte(a, acc);
        tx_data  = bb;
        tx_valid = 1'b1;
        tick(3);
        tx_valid = 1'b0;
        device_frame(4, 1'b1, got, started, ff);
        rst = 1'b1;
        tick(1);
        vectors++;
        if ({ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, err} !== 6'b001000) begin
            miscompares++;
            $display("[TB] FAIL rst_midframe: got %b expected 001000", {ps2_clk_oe, ps2_data_oe, tx_ready, busy, done, err});
        end
        rst = 1'b0;
        b_rise = clk_rises;
        tick(300);
        vectors++;
        if ((done_cnt - b_done) !== 0 || (err_cnt - b_err) !== 0 || (clk_rises - b_rise) !== 0) begin
            miscompares++;
            $display("[TB] FAIL rst_quiet: got done %0d err %0d starts %0d expected 0 0 0", done_cnt - b_done, err_cnt - b_err, clk_rises - b_rise);
        end
        send_byte(c, acc);
        device_frame(11, 1'b1, got, started, ff);
        wait_end(b_done + b_err, 300);
        vectors++;
        if (got !== ref_frame(c) || (done_cnt - b_done) !== 1 || !started) begin
            miscompares++;
            $display("[TB] FAIL post_rst_frame: got %b done %0d expected %b 1", got, done_cnt - b_done, ref_frame(c));
        end
    endtask

    initial begin
        test_reset();
        test_good_frames();
        test_back_to_back();
        test_no_clock();
        test_no_ack();
        test_stall();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
